sprite_scheduler: RTL

Sequences the pixel loader. It queues sprite-display requests from the game FSM and drives the loader's one-hot sprite-enable vector, one sprite at a time. For each request it restarts the loader, waits for the sprite frame to finish, holds it on screen for a programmable time, then redraws the background. It sits between the game controller and pixel_loader, and owns SPRITES_EN and the loader's reset.

---
 rtl/genius_pkg.sv | 51 +++++
 rtl/sprite_req_fifo.sv | 54 +++++
 rtl/sprite_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - sprite codes, SPRITES_EN bit map and scheduler state encoding
package genius_pkg;

  // Sprite codes, shared with pixel_loader MEM_SEL
  localparam logic [2:0] SPR_BG     = 3'd0;
  localparam logic [2:0] SPR_PWR    = 3'd1;
  localparam logic [2:0] SPR_RED    = 3'd2;
  localparam logic [2:0] SPR_GREEN  = 3'd3;
  localparam logic [2:0] SPR_BLUE   = 3'd4;
  localparam logic [2:0] SPR_YELLOW = 3'd5;
  localparam logic [2:0] SPR_WIN    = 3'd6;
  localparam logic [2:0] SPR_LOSE   = 3'd7;

  localparam int EN_BG     = 7;
  localparam int EN_BLUE   = 6;
  localparam int EN_GREEN  = 5;
  localparam int EN_RED    = 4;
  localparam int EN_YELLOW = 3;
  localparam int EN_LOSE   = 2;
  localparam int EN_WIN    = 1;
  localparam int EN_PWR    = 0;

  localparam logic [7:0] SPRITES_BG_ONLY = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DRAW     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_BG_START = 3'd4,
    ST_BG_DRAW  = 3'd5
  } sched_state_t;

  function automatic logic [7:0] sprite_onehot(input logic [2:0] code);
    logic [7:0] en;
    en = '0;
    case (code)
      SPR_BG:     en[EN_BG]     = 1'b1;
      SPR_PWR:    en[EN_PWR]    = 1'b1;
      SPR_RED:    en[EN_RED]    = 1'b1;
      SPR_GREEN:  en[EN_GREEN]  = 1'b1;
      SPR_BLUE:   en[EN_BLUE]   = 1'b1;
      SPR_YELLOW: en[EN_YELLOW] = 1'b1;
      SPR_WIN:    en[EN_WIN]    = 1'b1;
      SPR_LOSE:   en[EN_LOSE]   = 1'b1;
      default:    en            = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sprite_req_fifo.sv
// rtl/sprite_req_fifo.sv - synchronous request queue with flush; flush wins over push and pop
module sprite_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - queues sprite requests and sequences pixel_loader restarts, hold and background redraw
module sprite_scheduler
  import genius_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 25,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_ID,
  output logic       REQ_READY,
  input  logic       FLUSH,
  input  logic       LOAD_DONE,
  output logic [7:0] SPRITES_EN,
  output logic       LOADER_RESET,
  output logic       BUSY,
  output logic [2:0] ACTIVE_ID
);

  localparam int              HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam int              QCW       = $clog2(FIFO_DEPTH) + 1;

  sched_state_t     state;
  logic [2:0]       active_code;
  logic [CNT_W-1:0] hold_cnt;
  logic             sprite_phase;

  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic             q_pop;
  logic [2:0]       q_head;
  logic [QCW-1:0]   q_count;

  assign sprite_phase = (state == ST_START) || (state == ST_DRAW) || (state == ST_HOLD);
  assign q_push       = REQ_VALID && REQ_READY;
  assign q_pop        = (state == ST_IDLE) && !q_empty && !FLUSH;
  assign REQ_READY    = !q_full;
  assign BUSY         = (state != ST_IDLE) || (q_count != '0);

  sprite_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_req_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (FLUSH),
    .push      (q_push),
    .push_data (REQ_ID),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Loader-facing outputs are a registered decode of the current state, so they
  // trail the state register by one edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_BG_START;
      active_code  <= SPR_BG;
      hold_cnt     <= '0;
      SPRITES_EN   <= SPRITES_BG_ONLY;
      LOADER_RESET <= 1'b1;
      ACTIVE_ID    <= SPR_BG;
    end else begin
      LOADER_RESET <= (state == ST_START) || (state == ST_BG_START);
      SPRITES_EN   <= sprite_phase ? (SPRITES_BG_ONLY | sprite_onehot(active_code))
                                   : SPRITES_BG_ONLY;
      ACTIVE_ID    <= sprite_phase ? active_code : SPR_BG;

      if (FLUSH && sprite_phase) begin
        // Abort: drop the sprite from the screen at once, background restart follows.
        state        <= ST_BG_START;
        active_code  <= SPR_BG;
        SPRITES_EN   <= SPRITES_BG_ONLY;
        ACTIVE_ID    <= SPR_BG;
        LOADER_RESET <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (q_pop) begin
              active_code <= q_head;
              state       <= ST_START;
            end
          end
          ST_START: state <= ST_DRAW;
          ST_DRAW: begin
            if (LOAD_DONE) begin
              hold_cnt <= '0;
              // A background request is its own redraw, so no hold and no second restart.
              state    <= (active_code == SPR_BG) ? ST_IDLE : ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state <= ST_BG_START;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_BG_START: begin
            active_code <= SPR_BG;
            state       <= ST_BG_DRAW;
          end
          ST_BG_DRAW: begin
            if (LOAD_DONE) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_BG_START;
        endcase
      end
    end
  end

endmodule
